// File: rtl/clock_div_multi.sv
// Multi-channel programmable clock divider. Every channel has a registered ~50% clock,
// a period-start pulse and a shadowed divisor that is loaded only at a period boundary.
module clock_div_multi #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned CNT_W   = 25,
    parameter int unsigned DEF_DIV = 12_000_000,
    parameter int unsigned CH_W    = 4
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic [NUM_CH-1:0] en_in,
    input  logic              sync_in,
    input  logic              div_valid_in,
    input  logic [CH_W-1:0]   div_ch_in,
    input  logic [CNT_W-1:0]  div_val_in,
    output logic              div_ready_out,
    output logic [NUM_CH-1:0] clk_div_out,
    output logic [NUM_CH-1:0] pulse_out,
    output logic [NUM_CH-1:0] active_out
);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    localparam logic [CNT_W-1:0] DEF_N = (DEF_DIV < 2) ? CNT_W'(2) : CNT_W'(DEF_DIV);

    state_t             st_q   [NUM_CH];
    state_t             st_d   [NUM_CH];
    logic [CNT_W-1:0]   cnt_q  [NUM_CH];
    logic [CNT_W-1:0]   cnt_d  [NUM_CH];
    logic [CNT_W-1:0]   div_q  [NUM_CH];
    logic [CNT_W-1:0]   div_d  [NUM_CH];
    logic [CNT_W-1:0]   shd_q  [NUM_CH];
    logic [CNT_W-1:0]   shd_d  [NUM_CH];
    logic [CNT_W:0]     high_d [NUM_CH];
    logic [NUM_CH-1:0]  pend_q, pend_d;
    logic [NUM_CH-1:0]  apply, wr_ch;
    logic [NUM_CH-1:0]  clk_d, pulse_d, active_d;
    logic [CNT_W-1:0]   wr_val;

    // Writes to channels outside the array see ready=1 and are discarded.
    always_comb begin
        div_ready_out = 1'b1;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (div_ch_in == CH_W'(i) && pend_q[i]) div_ready_out = 1'b0;
        end
    end

    assign wr_val = (div_val_in < CNT_W'(2)) ? CNT_W'(2) : div_val_in;

    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            st_d[i]   = st_q[i];
            cnt_d[i]  = cnt_q[i];
            div_d[i]  = div_q[i];
            shd_d[i]  = shd_q[i];
            pend_d[i] = pend_q[i];
            apply[i]  = 1'b0;
            wr_ch[i]  = div_valid_in && div_ready_out && (div_ch_in == CH_W'(i));

            if (sync_in) begin
                cnt_d[i] = '0;
                if (en_in[i]) begin
                    st_d[i]  = ST_RUN;
                    apply[i] = 1'b1;
                end else begin
                    st_d[i] = ST_IDLE;
                end
            end else if (st_q[i] == ST_IDLE) begin
                cnt_d[i] = '0;
                if (en_in[i]) begin
                    st_d[i]  = ST_RUN;
                    apply[i] = 1'b1;
                end
            end else if (cnt_q[i] == div_q[i] - CNT_W'(1)) begin
                cnt_d[i]  = '0;
                apply[i]  = 1'b1;
                if (!en_in[i]) st_d[i] = ST_IDLE;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end

            // A write can only land while pending is clear, so it never collides with an apply.
            if (apply[i] && pend_q[i]) begin
                div_d[i]  = shd_q[i];
                pend_d[i] = 1'b0;
            end
            if (wr_ch[i]) begin
                shd_d[i]  = wr_val;
                pend_d[i] = 1'b1;
            end

            high_d[i]   = ({1'b0, div_d[i]} + (CNT_W+1)'(1)) >> 1;
            active_d[i] = (st_d[i] == ST_RUN);
            clk_d[i]    = active_d[i] && ({1'b0, cnt_d[i]} < high_d[i]);
            pulse_d[i]  = active_d[i] && (cnt_d[i] == '0);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                st_q[i]  <= ST_IDLE;
                cnt_q[i] <= '0;
                div_q[i] <= DEF_N;
                shd_q[i] <= DEF_N;
            end
            pend_q      <= '0;
            clk_div_out <= '0;
            pulse_out   <= '0;
            active_out  <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                st_q[i]  <= st_d[i];
                cnt_q[i] <= cnt_d[i];
                div_q[i] <= div_d[i];
                shd_q[i] <= shd_d[i];
            end
            pend_q      <= pend_d;
            clk_div_out <= clk_d;
            pulse_out   <= pulse_d;
            active_out  <= active_d;
        end
    end

endmodule
